// File: rtl/hatch_pkg.sv
// Shared types and default constants for the egg-hatch display controller.
package hatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PAUSE,
        ALARM,
        DONE
    } state_t;

    localparam int DEF_TICKS_PER_STAGE = 1000;
    localparam int DEF_NUM_STAGES      = 12;
    localparam int DEF_TEMP_DEBOUNCE   = 8;

endpackage

// File: rtl/hatch_temp_debounce.sv
// Temperature-ok debouncer: accepts a new level after TEMP_DEBOUNCE consecutive
// disagreeing samples and strobes change for one cycle when it does.
module hatch_temp_debounce
    import hatch_pkg::*;
#(
    parameter int TEMP_DEBOUNCE = DEF_TEMP_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic temp_ok,
    output logic temp_good,
    output logic change
);

    localparam int                CNT_W    = (TEMP_DEBOUNCE > 1) ? $clog2(TEMP_DEBOUNCE + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TEMP_DEBOUNCE - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            temp_good <= 1'b1;
            change    <= 1'b0;
        end else begin
            change <= 1'b0;
            if (temp_ok == temp_good) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // This sample is the TEMP_DEBOUNCE-th disagreeing one in a row.
                cnt       <= '0;
                temp_good <= temp_ok;
                change    <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hatch_ctrl.sv
// Hatch sequence controller: steps the display stage on a tick timer with pause,
// debounced temperature alarm and restart. Define HATCH_LOOP_EN to loop after DONE.
module hatch_ctrl
    import hatch_pkg::*;
#(
    parameter int TICKS_PER_STAGE = DEF_TICKS_PER_STAGE,
    parameter int NUM_STAGES      = DEF_NUM_STAGES,
    parameter int TEMP_DEBOUNCE   = DEF_TEMP_DEBOUNCE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       temp_ok,
    output logic [3:0] stage,
    output logic       st,
    output logic       temp_alarm,
    output logic       done
);

    localparam int                  TIMER_W    = (TICKS_PER_STAGE > 1) ? $clog2(TICKS_PER_STAGE) : 1;
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TICKS_PER_STAGE - 1);
    localparam logic [3:0]          STAGE_LAST = 4'(NUM_STAGES - 1);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               temp_good;
    logic               temp_change;
    logic               timer_last;

    hatch_temp_debounce #(
        .TEMP_DEBOUNCE(TEMP_DEBOUNCE)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .temp_ok   (temp_ok),
        .temp_good (temp_good),
        .change    (temp_change)
    );

    assign timer_last = (timer == TIMER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            stage      <= '0;
            st         <= 1'b0;
            temp_alarm <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        timer <= '0;
                        stage <= '0;
                        st    <= 1'b1;
                    end
                end

                RUN, PAUSE: begin
                    // Alarm beats start beats pause beats timer advance.
                    if (!temp_good) begin
                        state      <= ALARM;
                        temp_alarm <= 1'b1;
                    end else if (start) begin
                        state <= RUN;
                        timer <= '0;
                        stage <= '0;
                    end else if (pause) begin
                        state <= (state == RUN) ? PAUSE : RUN;
                    end else if (state == RUN) begin
                        if (timer_last) begin
                            timer <= '0;
                            if (stage == STAGE_LAST) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                stage <= stage + 4'd1;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end

                ALARM: begin
                    // Stage and timer stay frozen; start and pause are ignored here.
                    if (temp_change && temp_good) begin
                        state      <= RUN;
                        temp_alarm <= 1'b0;
                    end
                end

                DONE: begin
                    if (start) begin
                        state <= RUN;
                        timer <= '0;
                        stage <= '0;
                        done  <= 1'b0;
                    end
`ifdef HATCH_LOOP_EN
                    else if (timer_last) begin
                        state <= RUN;
                        timer <= '0;
                        stage <= '0;
                        done  <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hatch_ctrl.sv
// Randomized scoreboard bench for hatch_ctrl against a tick-count reference model.
module tb_hatch_ctrl;

    localparam int T = 4;
    localparam int N = 12;
    localparam int D = 3;

    localparam int M_IDLE     = 0;
    localparam int M_RUNNING  = 1;
    localparam int M_PAUSED   = 2;
    localparam int M_ALARMED  = 3;
    localparam int M_FINISHED = 4;

    typedef struct packed {
        logic [3:0] stage;
        logic       st;
        logic       alarm;
        logic       done;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pause;
    logic       temp_ok;
    logic [3:0] stage;
    logic       st;
    logic       temp_alarm;
    logic       done;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    // Reference model: progress kept as total elapsed ticks, temperature as a sample history.
    int   m_mode;
    int   m_ticks;
    int   m_hold;
    bit   m_good;
    bit   hist[$];

    hatch_ctrl #(
        .TICKS_PER_STAGE(T),
        .NUM_STAGES     (N),
        .TEMP_DEBOUNCE  (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .temp_ok    (temp_ok),
        .stage      (stage),
        .st         (st),
        .temp_alarm (temp_alarm),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode  = M_IDLE;
        m_ticks = 0;
        m_hold  = 0;
        m_good  = 1'b1;
        hist.delete();
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   s;
        s       = m_ticks / T;
        e.stage = 4'((s > N - 1) ? N - 1 : s);
        e.st    = (m_mode != M_IDLE);
        e.alarm = (m_mode == M_ALARMED);
        e.done  = (m_mode == M_FINISHED);
        return e;
    endfunction

    function automatic void model_step(input bit s, input bit p, input bit t);
        bit all_dis;
        case (m_mode)
            M_IDLE: begin
                if (s) begin m_mode = M_RUNNING; m_ticks = 0; end
            end
            M_RUNNING, M_PAUSED: begin
                if (!m_good) m_mode = M_ALARMED;
                else if (s) begin m_mode = M_RUNNING; m_ticks = 0; end
                else if (p) m_mode = (m_mode == M_RUNNING) ? M_PAUSED : M_RUNNING;
                else if (m_mode == M_RUNNING) begin
                    m_ticks++;
                    if (m_ticks == N * T) begin m_mode = M_FINISHED; m_hold = 0; end
                end
            end
            M_ALARMED: begin
                if (m_good) m_mode = M_RUNNING;
            end
            M_FINISHED: begin
                if (s) begin m_mode = M_RUNNING; m_ticks = 0; end
`ifdef HATCH_LOOP_EN
                else begin
                    m_hold++;
                    if (m_hold == T) begin m_mode = M_RUNNING; m_ticks = 0; end
                end
`endif
            end
            default: m_mode = M_IDLE;
        endcase
        // Accepted level flips once the last D samples all disagree with it.
        hist.push_back(t);
        if (hist.size() > D) void'(hist.pop_front());
        if (hist.size() == D) begin
            all_dis = 1'b1;
            foreach (hist[i]) if (hist[i] == m_good) all_dis = 1'b0;
            if (all_dis) m_good = !m_good;
        end
    endfunction

    task automatic step(input bit s, input bit p, input bit t);
        start   = s;
        pause   = p;
        temp_ok = t;
        @(posedge clk);
        model_step(s, p, t);
        sb_q.push_back(model_out());
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {25'd0, stage, st, temp_alarm, done}, 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        rst   = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("scoreboard {stage,st,alarm,done}", {25'd0, stage, st, temp_alarm, done}, {25'd0, e});
        end
    end

    initial begin
        bit tmp;
        rst     = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        temp_ok = 1'b1;
        model_reset();
        #1;
        rst = 1'b1;
        #2;
        check("reset_state", {25'd0, stage, st, temp_alarm, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Without start the controller must stay idle.
        run(3);

        // Full sequence to completion.
        step(1'b1, 1'b0, 1'b1);
        run(48);
        check("complete_stage", {28'd0, stage}, 32'd11);
        check("complete_done", {31'd0, done}, 32'd1);
        run(100);
`ifndef HATCH_LOOP_EN
        check("done_persists", {31'd0, done}, 32'd1);
`endif

        // Pause at stage 5, timer 2.
        step(1'b1, 1'b0, 1'b1);
        run(22);
        step(1'b0, 1'b1, 1'b1);
        run(20);
        check("paused_stage", {28'd0, stage}, 32'd5);
        step(1'b0, 1'b1, 1'b1);
        run(1);
        check("resume_plus1", {28'd0, stage}, 32'd5);
        run(1);
        check("resume_plus2", {28'd0, stage}, 32'd6);

        // Temperature glitch shorter than the debounce, then a real excursion.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        check("short_glitch_no_alarm", {31'd0, temp_alarm}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        check("alarm_raised", {31'd0, temp_alarm}, 32'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        run(12);

        // Start and pause together at stage 9.
        step(1'b1, 1'b0, 1'b1);
        run(36);
        step(1'b1, 1'b1, 1'b1);
        check("restart_stage", {28'd0, stage}, 32'd0);
        run(4);
        check("restart_not_paused", {28'd0, stage}, 32'd1);

        // Asynchronous reset at stage 7.
        step(1'b1, 1'b0, 1'b1);
        run(29);
        do_reset();
        run(5);

        // Randomized traffic with temperature runs and occasional resets.
        tmp = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) tmp = !tmp;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, tmp);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
